fsm_seq: RTL and testbench
==========================

# fsm_seq

Control FSM for a serial-start timer. It watches a serial `data` stream for the start pattern 1101, then enables a downstream shift register for a fixed number of cycles. It then holds `counting` until the external counter reports completion, and holds `done` until the user acknowledges. It sits between the serial input front end and the shift/counter datapath, which it drives.

## Interface
- `SHIFT_CYCLES`, default 4: number of consecutive cycles `shift_ena` is held high after the pattern is detected; legal range is 1..255.
- `clk` input 1: single clock; all state updates occur on the rising edge.
- `reset` input 1: asynchronous, active-low reset; forces the idle state immediately.
- `data` input 1: serial bit stream, sampled on each rising edge while searching.
- `done_counting` input 1: high when the external counter has finished; sampled only while counting.
- `ack` input 1: user acknowledge; sampled only while `done` is high.
- `shift_ena` output 1: shift-register enable, high for exactly `SHIFT_CYCLES` cycles.
- `counting` output 1: high while waiting for `done_counting`.
- `done` output 1: high while waiting for `ack`.

## Operation
- All three outputs are Moore outputs, decoded from the registered state only. They are registered or glitch-free, and at most one output is high in any cycle.
- State `S_IDLE` (also the reset state):
  - `data`=1 goes to `S_1`; `data`=0 stays in `S_IDLE`.
- State `S_1`:
  - `data`=1 goes to `S_11`; `data`=0 goes to `S_IDLE`.
- State `S_11`:
  - `data`=1 stays in `S_11`, so overlapping 111…101 is detected; `data`=0 goes to `S_110`.
- State `S_110`:
  - `data`=1 goes to `S_SHIFT` and loads the shift counter with `SHIFT_CYCLES`-1; `data`=0 goes to `S_IDLE`.
- State `S_SHIFT`:
  - `shift_ena`=1 and the counter decrements each cycle.
  - When the counter is 0, the next state is `S_COUNT`.
  - `data` is ignored.
- State `S_COUNT`:
  - `counting`=1.
  - `done_counting`=1 goes to `S_WAIT`; otherwise stay in `S_COUNT`.
- State `S_WAIT`:
  - `done`=1.
  - `ack`=1 goes to `S_IDLE`; otherwise stay in `S_WAIT`.
- Inputs are ignored outside the states that sample them:
  - `data` outside `S_IDLE`..`S_110`.
  - `done_counting` outside `S_COUNT`.
  - `ack` outside `S_WAIT`.
- Unreachable state encodings recover to `S_IDLE` on the next edge.

## Timing
- Reset:
  - Asserting `reset` (low) asynchronously forces `S_IDLE`, clears the counter, and drives all outputs to 0 with no clock needed. This applies in every state, including mid-shift and mid-count.
  - After `reset` returns high, the first pattern bit is sampled on the next rising edge.
- Detection latency: the edge that samples the final '1' of 1101 raises `shift_ena` in the following cycle.
- `shift_ena` stays high for exactly `SHIFT_CYCLES` clock cycles; `counting` rises in the cycle immediately after the last shift cycle.
- `done_counting` handshake:
  - It is sampled on the rising edge; if high, `counting` falls and `done` rises in the next cycle.
  - `done_counting` already high on entry to `S_COUNT` still produces a minimum of one `counting` cycle.
- `ack` handshake:
  - If `ack` is high on an edge in `S_WAIT`, `done` falls in the next cycle.
  - The search restarts from `S_IDLE`, and the `data` sampled on that same edge is discarded.
- `ack` already high on entry to `S_WAIT` still produces a minimum of one `done` cycle.

## Structure
- Shared package `fsm_seq_pkg`:
  - State enum (`S_IDLE`, `S_1`, `S_11`, `S_110`, `S_SHIFT`, `S_COUNT`, `S_WAIT`).
  - Pattern constant 4'b1101.
  - Counter width function, `$clog2(SHIFT_CYCLES)` with a minimum of 1.
- One natural sub-module, `fsm_seq_shift_cnt`: a loadable down-counter with a `zero` flag that controls `S_SHIFT` exit. Keep the FSM's next-state and output logic in the top module.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `data`=1 → all outputs 0 and state `S_IDLE`. Release, apply `data` 1,1,0,1 → `shift_ena`=1 for exactly 4 cycles starting the cycle after the 4th bit, then `counting`=1.
- Overlap: apply `data` 1,1,1,1,0,1 → detection after the 6th bit. Apply 1,1,0,0,1,1,0,1 → no detection after 1100, detection after the final 1.
- Counting handshake: in `S_COUNT`, hold `done_counting`=0 for 5 cycles → `counting` stays 1. Raise it → next cycle `counting`=0 and `done`=1.
- Ack handshake: in `S_WAIT`, hold `ack`=0 for 3 cycles with `data` toggling → `done` stays 1. Raise `ack` → `done`=0 next cycle. A fresh 1101 is then needed to re-trigger.
- Asynchronous reset mid-operation: drop `reset` during shift cycle 2, and again during `S_COUNT` → outputs go to 0 before the next edge, and the state returns to `S_IDLE`.
- Parameter: with `SHIFT_CYCLES`=1 and with `SHIFT_CYCLES`=7 → `shift_ena` width is exactly 1 and exactly 7 cycles respectively; `done_counting` high early has no effect during shifting.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the serial-start timer control FSM.
package fsm_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_1     = 3'd1,
        S_11    = 3'd2,
        S_110   = 3'd3,
        S_SHIFT = 3'd4,
        S_COUNT = 3'd5,
        S_WAIT  = 3'd6
    } state_t;

    localparam logic [3:0] START_PATTERN = 4'b1101;

    // Counter holds SHIFT_CYCLES-1 down to 0; a single-cycle shift still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/fsm_seq_if.sv
// Serial input and datapath-control signals between the front end and fsm_seq.
interface fsm_seq_if;

    logic data;
    logic done_counting;
    logic ack;
    logic shift_ena;
    logic counting;
    logic done;

    modport master (
        output data, done_counting, ack,
        input  shift_ena, counting, done
    );

    modport slave (
        input  data, done_counting, ack,
        output shift_ena, counting, done
    );

endinterface

// File: rtl/fsm_seq_shift_cnt.sv
// Loadable down-counter that times the shift phase; zero marks the last shift cycle.
module fsm_seq_shift_cnt #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fsm_seq.sv
// Control FSM: detects 1101 on data, pulses shift_ena for SHIFT_CYCLES cycles,
// then waits on done_counting (counting) and ack (done).
module fsm_seq
    import fsm_seq_pkg::*;
#(
    parameter int unsigned SHIFT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    fsm_seq_if.slave   bus
);

    localparam int unsigned     CW       = cnt_width(SHIFT_CYCLES);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(SHIFT_CYCLES - 1);

    state_t state_q;
    state_t state_d;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;
    logic   shift_ena_q, shift_ena_d;
    logic   counting_q,  counting_d;
    logic   done_q,      done_d;

    fsm_seq_shift_cnt #(
        .WIDTH (CW)
    ) u_shift_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            S_IDLE:  if (bus.data == START_PATTERN[3]) state_d = S_1;
            S_1:     state_d = (bus.data == START_PATTERN[2]) ? S_11 : S_IDLE;
            // A further 1 keeps the "11" prefix alive so 111...101 still matches.
            S_11:    if (bus.data == START_PATTERN[1]) state_d = S_110;
            S_110: begin
                if (bus.data == START_PATTERN[0]) begin
                    state_d  = S_SHIFT;
                    cnt_load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_zero) begin
                    state_d = S_COUNT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_COUNT: if (bus.done_counting) state_d = S_WAIT;
            S_WAIT:  if (bus.ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered copies of the next-state decode, so they line up
    // with state_q yet come straight from flops.
    always_comb begin
        shift_ena_d = (state_d == S_SHIFT);
        counting_d  = (state_d == S_COUNT);
        done_d      = (state_d == S_WAIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shift_ena_q <= 1'b0;
            counting_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_ena_q <= shift_ena_d;
            counting_q  <= counting_d;
            done_q      <= done_d;
        end
    end

    assign bus.shift_ena = shift_ena_q;
    assign bus.counting  = counting_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_fsm_seq.sv
// Scoreboard bench: three fsm_seq instances (SHIFT_CYCLES 1, 4, 7) share one stimulus stream.
module tb_fsm_seq;
    import fsm_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic data;
    logic dc;
    logic ack;

    always #5 clk = ~clk;

    fsm_seq_if bus1 ();
    fsm_seq_if bus4 ();
    fsm_seq_if bus7 ();

    assign bus1.data = data; assign bus1.done_counting = dc; assign bus1.ack = ack;
    assign bus4.data = data; assign bus4.done_counting = dc; assign bus4.ack = ack;
    assign bus7.data = data; assign bus7.done_counting = dc; assign bus7.ack = ack;

    fsm_seq #(.SHIFT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    fsm_seq #(.SHIFT_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    fsm_seq #(.SHIFT_CYCLES(7)) dut7 (.clk(clk), .reset(reset), .bus(bus7.slave));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase 0..3 = pattern progress, 4 shift, 5 count, 6 wait.
    localparam int NS [3] = '{1, 4, 7};
    int ph   [3] = '{0, 0, 0};
    int left [3] = '{0, 0, 0};
    logic [8:0] sb [$];

    function automatic logic [2:0] model_out(input int p);
        return {p == 4, p == 5, p == 6};
    endfunction

    task automatic model_step(input logic r, input logic d, input logic dcv, input logic av);
        for (int k = 0; k < 3; k++) begin
            if (!r) begin
                ph[k]   = 0;
                left[k] = 0;
            end else begin
                case (ph[k])
                    0: ph[k] = d ? 1 : 0;
                    1: ph[k] = d ? 2 : 0;
                    2: ph[k] = d ? 2 : 3;
                    3: begin
                        if (d) begin
                            ph[k]   = 4;
                            left[k] = NS[k];
                        end else begin
                            ph[k] = 0;
                        end
                    end
                    4: begin
                        left[k]--;
                        if (left[k] == 0) ph[k] = 5;
                    end
                    5: if (dcv) ph[k] = 6;
                    6: if (av) ph[k] = 0;
                    default: ph[k] = 0;
                endcase
            end
        end
    endtask

    task automatic push_expected();
        sb.push_back({model_out(ph[0]), model_out(ph[1]), model_out(ph[2])});
    endtask

    task automatic compare_outputs(input string tag);
        logic [8:0] e;
        e = sb.pop_front();
        check_val({tag, "_n1"}, {5'b0, bus1.shift_ena, bus1.counting, bus1.done}, {5'b0, e[8:6]});
        check_val({tag, "_n4"}, {5'b0, bus4.shift_ena, bus4.counting, bus4.done}, {5'b0, e[5:3]});
        check_val({tag, "_n7"}, {5'b0, bus7.shift_ena, bus7.counting, bus7.done}, {5'b0, e[2:0]});
    endtask

    task automatic step(input string tag, input logic r, input logic d, input logic dcv, input logic av);
        @(negedge clk);
        reset = r;
        data  = d;
        dc    = dcv;
        ack   = av;
        model_step(r, d, dcv, av);
        push_expected();
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic send_bits(input string tag, input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(tag, 1'b1, bits[i], 1'b0, 1'b0);
        end
    endtask

    // Drops reset between edges and checks outputs clear with no clock.
    task automatic async_drop(input string tag);
        #2;
        reset = 1'b0;
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        push_expected();
        #1;
        compare_outputs(tag);
        check_val({tag, "_state"}, 8'(dut4.state_q), 8'(S_IDLE));
    endtask

    initial begin
        reset = 1'b0;
        data  = 1'b1;
        dc    = 1'b0;
        ack   = 1'b0;

        step("rst", 1'b0, 1'b1, 1'b0, 1'b0);
        step("rst", 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("rst_state", 8'(dut4.state_q), 8'(S_IDLE));

        send_bits("pat1", 16'b1101, 4);
        for (int i = 0; i < 3; i++) step("shift_dc", 1'b1, 1'($urandom % 2), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step("count", 1'b1, 1'b0, 1'b0, 1'b0);
        step("dc_rise", 1'b1, 1'b0, 1'b1, 1'b0);
        step("wait", 1'b1, 1'b0, 1'b0, 1'b0);
        step("wait", 1'b1, 1'b1, 1'b0, 1'b0);
        step("wait", 1'b1, 1'b0, 1'b0, 1'b0);
        step("ack", 1'b1, 1'b1, 1'b0, 1'b1);
        send_bits("discard", 16'b101, 3);
        send_bits("idle", 16'b00, 2);

        send_bits("ovl", 16'b111101, 6);
        for (int i = 0; i < 12; i++) step("min_one", 1'b1, 1'b0, 1'b1, 1'b1);
        send_bits("ovl2", 16'b11001101, 8);

        step("shift2", 1'b1, 1'b0, 1'b0, 1'b0);
        async_drop("rst_shift");
        step("rst_hold", 1'b0, 1'b1, 1'b0, 1'b0);

        send_bits("pat3", 16'b1101, 4);
        for (int i = 0; i < 5; i++) step("to_count", 1'b1, 1'b0, 1'b0, 1'b0);
        async_drop("rst_count");
        step("rst_hold", 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step("rand",
                 ($urandom % 60) != 0,
                 1'($urandom % 2),
                 ($urandom % 4) == 0,
                 ($urandom % 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
